// File: rtl/rs422_frame_echo_sched_pkg.sv
// Shared types and default timing for the RS422 frame echo scheduler.
// Timing defaults are expressed in 16x-oversampled clock ticks.
package rs422_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int CHAR_BITS       = 10;
  localparam int DEF_GAP_TICKS   = 2 * CHAR_BITS * OVERSAMPLE;
  localparam int DEF_ACK_TIMEOUT = 4 * OVERSAMPLE;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RECV    = 4'd1,
    CLOSE   = 4'd2,
    RD_ADDR = 4'd3,
    RD_WAIT = 4'd4,
    LOAD    = 4'd5,
    STROBE  = 4'd6,
    ACK     = 4'd7,
    DRAIN   = 4'd8
  } state_t;

  // States in which an incoming byte is stored rather than dropped.
  function automatic logic is_rx_state(input state_t s);
    return (s == IDLE) || (s == RECV);
  endfunction

endpackage

// File: rtl/rs422_frame_echo_sched_gap_timer.sv
// Up-counter with synchronous clear and a terminal-count pulse on tick TICKS-1.
// Used both for the inter-byte gap and for the transmit-acknowledge timeout.
module rs422_gap_timer
  import rs422_pkg::*;
#(
  parameter int TICKS = DEF_GAP_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = $clog2(TICKS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Clear has priority so a fresh event in the same tick never reports expiry.
  always_comb begin
    done = enable && !clear && (count_r == LAST);
  end

  // Tick counter; wraps after the terminal tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      count_r <= done ? {CNT_W{1'b0}} : count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/rs422_frame_echo_sched.sv
// Collects received bytes into the loopback RAM, closes a frame on gap or full buffer,
// then replays it through uarttx with the wrsig/busy handshake.
module rs422_frame_echo_sched
  import rs422_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int GAP_TICKS   = DEF_GAP_TICKS,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic              tx_wrsig,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   frame_len,
  output logic              busy,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_WR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  state_t          state_r;
  state_t          state_s;
  logic            rx_prev_r;
  logic            rise_s;
  logic            accept_s;
  logic            drop_s;
  logic            last_wr_s;
  logic            last_rd_s;
  logic [ADDR_W:0] wr_ptr_r;
  logic [ADDR_W:0] rd_ptr_r;
  logic            gap_clear_s;
  logic            gap_en_s;
  logic            gap_done_s;
  logic            ack_clear_s;
  logic            ack_en_s;
  logic            ack_done_s;

  // Byte events: one per rx_valid rising edge, stored or dropped depending on state.
  always_comb begin
    rise_s      = rx_valid && !rx_prev_r;
    accept_s    = rise_s && is_rx_state(state_r);
    drop_s      = rise_s && !is_rx_state(state_r);
    last_wr_s   = (wr_ptr_r == LAST_WR);
    last_rd_s   = ((rd_ptr_r + ONE) == frame_len);
    gap_en_s    = (state_r == RECV);
    gap_clear_s = accept_s || (state_r != RECV);
    ack_en_s    = (state_r == ACK);
    ack_clear_s = (state_r != ACK);
  end

  rs422_gap_timer #(.TICKS(GAP_TICKS)) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (gap_clear_s),
    .enable (gap_en_s),
    .done   (gap_done_s)
  );

  rs422_gap_timer #(.TICKS(ACK_TIMEOUT)) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (ack_clear_s),
    .enable (ack_en_s),
    .done   (ack_done_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a full buffer closes on the final write without waiting for the gap.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = last_wr_s ? CLOSE : RECV;
        end else begin
          state_s = IDLE;
        end
      end
      RECV: begin
        if (accept_s) begin
          state_s = last_wr_s ? CLOSE : RECV;
        end else if (gap_done_s) begin
          state_s = CLOSE;
        end else begin
          state_s = RECV;
        end
      end
      CLOSE:   state_s = RD_ADDR;
      RD_ADDR: state_s = RD_WAIT;
      RD_WAIT: state_s = LOAD;
      LOAD:    state_s = STROBE;
      STROBE: begin
        if (!tx_busy) begin
          state_s = ACK;
        end else begin
          state_s = STROBE;
        end
      end
      ACK: begin
        if (tx_busy) begin
          state_s = DRAIN;
        end else if (ack_done_s) begin
          state_s = STROBE;
        end else begin
          state_s = ACK;
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          state_s = last_rd_s ? IDLE : RD_ADDR;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: RAM write port, pointers, replay registers and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_prev_r <= 1'b0;
      wr_ptr_r  <= {(ADDR_W + 1){1'b0}};
      rd_ptr_r  <= {(ADDR_W + 1){1'b0}};
      ram_we    <= 1'b0;
      ram_waddr <= {ADDR_W{1'b0}};
      ram_wdata <= 8'h00;
      ram_raddr <= {ADDR_W{1'b0}};
      tx_data   <= 8'h00;
      tx_wrsig  <= 1'b0;
      frame_len <= {(ADDR_W + 1){1'b0}};
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rx_prev_r <= rx_valid;
      ram_we    <= 1'b0;
      tx_wrsig  <= 1'b0;
      if (accept_s) begin
        ram_we    <= 1'b1;
        ram_waddr <= wr_ptr_r[ADDR_W-1:0];
        ram_wdata <= rx_data;
        wr_ptr_r  <= wr_ptr_r + ONE;
      end
      if (drop_s) begin
        overflow <= 1'b1;
      end
      case (state_r)
        CLOSE: begin
          frame_len <= wr_ptr_r;
          rd_ptr_r  <= {(ADDR_W + 1){1'b0}};
          wr_ptr_r  <= {(ADDR_W + 1){1'b0}};
          busy      <= 1'b1;
        end
        RD_ADDR: ram_raddr <= rd_ptr_r[ADDR_W-1:0];
        LOAD:    tx_data   <= ram_rdata;
        STROBE: begin
          if (!tx_busy) begin
            tx_wrsig <= 1'b1;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            rd_ptr_r <= rd_ptr_r + ONE;
            if (last_rd_s) begin
              busy <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs422_frame_echo_sched.sv
// Randomized scoreboard bench: a frame-level reference model predicts RAM writes and
// replayed bytes; a monitor pops and compares whenever the DUT writes or strobes.
module tb_rs422_frame_echo_sched;

  localparam int ADDR_W   = 6;
  localparam int DEPTH    = 64;
  localparam int GAP      = 320;
  localparam int BUSY_LEN = 20;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              tx_busy;
  logic              tx_wrsig;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [7:0]        ram_rdata;
  logic [7:0]        tx_data;
  logic [ADDR_W:0]   frame_len;
  logic              busy;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_wr[$];
  int exp_tx[$];
  int strobe_cyc[$];
  int strobe_cnt = 0;
  int wr_cnt = 0;
  bit ignore_next = 1'b0;
  logic [7:0] mem [DEPTH];

  rs422_frame_echo_sched dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_wrsig(tx_wrsig), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .frame_len(frame_len), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Dual-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // uarttx model: busy for BUSY_LEN clocks after each strobe, optionally ignoring one.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_wrsig) begin
        if (ignore_next) begin
          ignore_next = 1'b0;
        end else begin
          @(negedge clk);
          tx_busy = 1'b1;
          repeat (BUSY_LEN) @(negedge clk);
          tx_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every RAM write and every transmit strobe against the model.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (ram_we) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: addr=%0d data=0x%0h, required no write", ram_waddr, ram_wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", int'(ram_waddr), e / 256);
          chk("wr_data", int'(ram_wdata), e % 256);
        end
      end
      if (tx_wrsig) begin
        strobe_cnt++;
        strobe_cyc.push_back(cyc);
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: data=0x%0h, required no strobe", tx_data);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_data", int'(tx_data), e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int space);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(hold);
    rx_valid = 1'b0;
    tick(space);
  endtask

  // Reference model: every byte of a frame accepted while idle lands at its frame index
  // and is later echoed once, in order.
  task automatic send_frame(input bq_t bytes, input int hold_max, input int space_max,
                            output int last_hs);
    int h;
    int s;
    last_hs = 0;
    foreach (bytes[i]) begin
      h = $urandom_range(hold_max, 1);
      s = $urandom_range(space_max, 1);
      exp_wr.push_back(i * 256 + int'(bytes[i]));
      exp_tx.push_back(int'(bytes[i]));
      send_byte(bytes[i], h, s);
      last_hs = h + s;
    end
  endtask

  // Frame must close after the gap (or at once when full) with the right length.
  task automatic wait_close(input int n, input int last_hs);
    int k = 0;
    while (!busy && k < GAP + 60) begin
      tick(1);
      k++;
    end
    chk("busy_rise", int'(busy), 1);
    if (n == DEPTH) chk_range("close_full_nogap", k, 0, 3);
    else            chk_range("close_after_gap", k, GAP - last_hs - 4, GAP - last_hs + 4);
    chk("frame_len", int'(frame_len), n);
  endtask

  task automatic wait_done(input int n_strobes, input int s0);
    int k = 0;
    int lim;
    lim = n_strobes * (BUSY_LEN + 80) + 200;
    while (busy && k < lim) begin
      tick(1);
      k++;
    end
    chk("busy_fall", int'(busy), 0);
    chk("strobe_count", strobe_cnt - s0, n_strobes);
    tick(3);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("tx_queue_drained", exp_tx.size(), 0);
  endtask

  task automatic rand_bytes(input int n, output bq_t q);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255, 0)));
  endtask

  initial begin
    bq_t q;
    int hs;
    int s0;
    int w0;
    int k;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(3);
    chk("rst_tx_wrsig", int'(tx_wrsig), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_frame_len", int'(frame_len), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    reset = 1'b0;
    tick(2);

    // Three spaced bytes then silence.
    q = {8'h41, 8'h42, 8'h43};
    s0 = strobe_cnt;
    foreach (q[i]) begin
      exp_wr.push_back(i * 256 + int'(q[i]));
      exp_tx.push_back(int'(q[i]));
      send_byte(q[i], 2, 158);
    end
    wait_close(3, 160);
    wait_done(3, s0);

    // Full buffer of back-to-back bytes closes without a gap wait.
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(8'(i));
    s0 = strobe_cnt;
    send_frame(q, 1, 1, hs);
    wait_close(DEPTH, hs);
    wait_done(DEPTH, s0);

    // Random frames; the next frame restarts at address 0.
    for (int f = 0; f < 3; f++) begin
      rand_bytes($urandom_range(DEPTH, 1), q);
      s0 = strobe_cnt;
      send_frame(q, 4, 60, hs);
      wait_close(q.size(), hs);
      wait_done(q.size(), s0);
    end

    // Byte arriving mid-replay is dropped and flags a sticky overflow.
    rand_bytes(2, q);
    s0 = strobe_cnt;
    send_frame(q, 3, 40, hs);
    wait_close(2, hs);
    tick(10);
    chk("overflow_before_drop", int'(overflow), 0);
    send_byte(8'h55, 2, 5);
    chk("overflow_set", int'(overflow), 1);
    wait_done(2, s0);
    tick(40);
    chk("overflow_sticky", int'(overflow), 1);

    // rx_valid held for 20 clocks counts as one byte.
    w0 = wr_cnt;
    s0 = strobe_cnt;
    exp_wr.push_back(8'hA7);
    exp_tx.push_back(8'hA7);
    send_byte(8'hA7, 20, 3);
    wait_close(1, 23);
    chk("long_valid_one_write", wr_cnt - w0, 1);
    wait_done(1, s0);

    // Ignored first strobe is re-issued after the acknowledge timeout with the same byte.
    ignore_next = 1'b1;
    s0 = strobe_cnt;
    exp_wr.push_back(8'h5A);
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'h5A);
    send_byte(8'h5A, 2, 2);
    wait_close(1, 4);
    wait_done(2, s0);
    chk_range("reissue_interval", strobe_cyc[strobe_cyc.size() - 1] - strobe_cyc[strobe_cyc.size() - 2], 64, 67);

    // Reset during the second of three replayed bytes discards the frame.
    rand_bytes(3, q);
    s0 = strobe_cnt;
    send_frame(q, 2, 30, hs);
    wait_close(3, hs);
    k = 0;
    while (strobe_cnt < s0 + 2 && k < 500) begin
      tick(1);
      k++;
    end
    chk("second_strobe_seen", strobe_cnt - s0, 2);
    tick(3);
    reset = 1'b1;
    tick(1);
    exp_tx.delete();
    chk("mid_rst_tx_wrsig", int'(tx_wrsig), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("mid_rst_frame_len", int'(frame_len), 0);
    chk("mid_rst_ram_we", int'(ram_we), 0);
    chk("mid_rst_tx_data", int'(tx_data), 0);
    tick(1);
    reset = 1'b0;
    k = 0;
    while (tx_busy && k < 100) begin
      tick(1);
      k++;
    end
    s0 = strobe_cnt;
    exp_wr.push_back(8'h7E);
    exp_tx.push_back(8'h7E);
    send_byte(8'h7E, 2, 2);
    wait_close(1, 4);
    wait_done(1, s0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
